// File: rtl/logic_gate_sweeper.sv
// logic_gate_sweeper: walks every input vector of an N-input gate, captures
// the resulting truth table and compares it against a reference table.
// Optional feature: define SWEEP_ERRCNT_EN to add the o_errCnt output, which
// counts captured entries that disagree with the reference.
module logic_gate_sweeper #(
   parameter int N = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [2:0]          i_op,
   input  logic                i_hold,
   input  logic [(1<<N)-1:0]   i_expected,
   output logic [N-1:0]        o_vec,
   output logic                o_y,
   output logic                o_busy,
   output logic                o_done,
   output logic [(1<<N)-1:0]   o_table,
   output logic                o_match
`ifdef SWEEP_ERRCNT_EN
   ,
   output logic [N:0]          o_errCnt
`endif
);

   localparam int W = 1 << N;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [N-1:0]   r_vec;
   logic [W-1:0]   r_table;
   logic [2:0]     r_op;
   logic           r_match;
   logic           w_y;
   logic           w_accept;
   logic           w_capture;
   logic           w_lastVec;
   logic [W-1:0]   w_tableNext;

   assign w_accept  = (r_state == IDLE) && i_start;
   assign w_capture = (r_state == SWEEP) && !i_hold;
   assign w_lastVec = (r_vec == {N{1'b1}});

   // Gate output: the latched op reduced across every bit of the current vector
   always_comb begin
      w_y = 1'b0;
      case (r_op)
         3'd0:    w_y = &r_vec;
         3'd1:    w_y = |r_vec;
         3'd2:    w_y = ^r_vec;
         3'd3:    w_y = ~&r_vec;
         3'd4:    w_y = ~|r_vec;
         3'd5:    w_y = ~^r_vec;
         3'd6:    w_y = r_vec[0];
         default: w_y = 1'b0;
      endcase
   end

   // Table as it will look once the current vector's result is written in
   always_comb begin
      w_tableNext        = r_table;
      w_tableNext[r_vec] = w_y;
   end

   // State register; reset aborts any sweep in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: DONE is a single-cycle visit before returning to IDLE
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (i_start) w_nextState = SWEEP;
         SWEEP:   if (w_capture && w_lastVec) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Sweep datapath: latch op on start, step the vector and record each result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec   <= '0;
         r_table <= '0;
         r_op    <= 3'd0;
         r_match <= 1'b0;
      end else if (w_accept) begin
         r_vec   <= '0;
         r_table <= '0;
         r_op    <= i_op;
         r_match <= 1'b0;
      end else if (w_capture) begin
         r_table <= w_tableNext;
         if (w_lastVec) begin
            r_match <= (w_tableNext == i_expected);
         end else begin
            r_vec <= r_vec + N'(1);
         end
      end
   end

`ifdef SWEEP_ERRCNT_EN
   logic [N:0] r_errCnt;

   // Count captured entries that differ from the reference; cleared on start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_errCnt <= '0;
      end else if (w_accept) begin
         r_errCnt <= '0;
      end else if (w_capture && (w_y != i_expected[r_vec])) begin
         r_errCnt <= r_errCnt + (N+1)'(1);
      end
   end

   assign o_errCnt = r_errCnt;
`endif

   assign o_vec   = r_vec;
   assign o_y     = w_y;
   assign o_busy  = (r_state != IDLE);
   assign o_done  = (r_state == DONE);
   assign o_table = r_table;
   assign o_match = r_match;

endmodule

// File: doc/logic_gate_sweeper.md
LOGIC_GATE_SWEEPER -- requirements
Module: logic_gate_sweeper

Interface
REQ-001 Parameter N, default 2, legal 1..6: number of gate inputs; truth table is 2^N entries.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 op  input  3  gate select; 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF (vec[0]), 7 constant 0.
REQ-006 hold  input  1  pause sweep while high.
REQ-007 expected  input  2^N  reference truth table; bit i is the expected y for vec == i.
REQ-008 vec  output  N  current stimulus vector.
REQ-009 y  output  1  combinational gate output of latched op applied to vec, as a reduction over all N bits.
REQ-010 busy  output  1  high in SWEEP and DONE.
REQ-011 done  output  1  one-cycle pulse when the sweep completes.
REQ-012 table  output  2^N  captured truth table; bit i = y observed at vec == i.
REQ-013 match  output  1  registered; table == expected at completion.

Function
REQ-014 FSM states: IDLE, SWEEP, DONE.
REQ-015 IDLE with start=1 at an edge: latch op, vec <= 0, table <= 0, match <= 0, go to SWEEP.
REQ-016 SWEEP, hold=0 at an edge: table[vec] <= y; if vec == 2^N-1, go to DONE, else vec <= vec+1.
REQ-017 SWEEP, hold=1: vec, table and state frozen; y continues to follow vec.
REQ-018 Entry to DONE: match <= (table with final entry written) == expected.
REQ-019 DONE lasts exactly one cycle: done=1, then IDLE; vec holds 2^N-1 until next start.
REQ-020 Latency: start sampled at edge k, no hold -> done high in the cycle after edge k+2^N.
REQ-021 start is ignored in SWEEP and DONE; op changes after latching are ignored until the next start.
REQ-022 table and match hold their values in IDLE until the next accepted start.
REQ-023 N=1: sweep covers vec 0 and 1; BUF and reductions degenerate to vec[0].

Reset
REQ-024 rst=1 asynchronously forces: state IDLE, vec 0, table 0, latched op 0, done 0, busy 0, match 0, err_cnt 0 (if present).
REQ-025 rst asserted mid-sweep aborts it; done is not pulsed; the first start after release runs a full fresh sweep.

Configuration
REQ-026 Macro SWEEP_ERRCNT_EN, when defined, adds output err_cnt (N+1 bits).
REQ-027 With the macro: err_cnt <= 0 on accepted start; err_cnt increments on each SWEEP capture edge where y != expected[vec]; it holds in DONE and IDLE.
REQ-028 Without the macro: no err_cnt port and no related logic; all other behaviour is identical.

Verification
REQ-029 N=2, op=0, expected=4'b1000, start pulse -> vec 0,1,2,3; done pulse in cycle after 4th edge post-start; table=4'b1000; match=1.
REQ-030 N=3, op=2, expected=8'h96 -> table=8'h96, match=1; same run with op=5 -> table=8'h69, match=0.
REQ-031 N=2, op=1, hold=1 for 3 cycles while vec=1 -> vec stays 1 for 3 cycles; done is delayed by 3 cycles; table=4'b1110.
REQ-032 start held high through an entire sweep -> exactly one sweep and one done pulse; a second sweep starts only when start is sampled in IDLE.
REQ-033 rst pulsed mid-way through a sweep at vec=2 -> all outputs 0 immediately, no done pulse; a following sweep produces the correct full table.
REQ-034 SWEEP_ERRCNT_EN defined, N=2, op=3, expected=4'b1000 -> table=4'b0111, match=0, err_cnt=4; an accepted start clears err_cnt to 0.
